// File: rtl/cpu_control.sv
// Multi-cycle control unit: fetches into IR, sequences each opcode, drives ALU/regfile/memory controls.
// Latency: ALU/li 4 cycles, ld/st 5 cycles, branch/jump/nop 3 cycles from FETCH to next FETCH.
// Backpressure: FETCH and MEM hold with address/we/wdata stable until mem_ready; each wait cycle adds one.
module cpu_control (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  ra_sel,
  output logic [3:0]  rb_sel,
  input  logic [15:0] a_data,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [3:0]  alu_op,
  output logic [11:0] inst12,
  output logic [15:0] pc,
  input  logic [15:0] alu_out,
  input  logic        alu_neg,
  input  logic        alu_zero,
  output logic        halted,
  output logic        instr_done
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_NEXTPC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LI   = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;
  localparam logic [3:0] OP_ST   = 4'd9;
  localparam logic [3:0] OP_BZ   = 4'd10;
  localparam logic [3:0] OP_BN   = 4'd11;
  localparam logic [3:0] OP_J    = 4'd12;
  localparam logic [3:0] OP_JR   = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd14;

  // ALU op codes used during PC update: 10 = pc+1, 11 = pc+disp, 12 = jump, 13 = register jump
  localparam logic [3:0] ALU_INC = 4'd10;
  localparam logic [3:0] ALU_BR  = 4'd11;
  localparam logic [3:0] ALU_J   = 4'd12;
  localparam logic [3:0] ALU_JR  = 4'd13;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [15:0] mar;
  logic [3:0]  opcode;
  logic        ir_ld;
  logic        mar_ld;
  logic        pc_ld;

  assign opcode    = ir[15:12];
  assign ra_sel    = ir[7:4];
  assign rb_sel    = ir[3:0];
  assign rf_waddr  = ir[11:8];
  assign inst12    = ir[11:0];
  assign mem_wdata = a_data;

  // State, IR, MAR and PC registers; reset returns to BOOT with all architectural state cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_BOOT;
      ir    <= 16'h0000;
      mar   <= 16'h0000;
      pc    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (ir_ld)  ir  <= mem_rdata;
      if (mar_ld) mar <= alu_out;
      if (pc_ld)  pc  <= alu_out;
    end
  end

  // Next-state and per-state control outputs; idle defaults keep memory and regfile quiet
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    rf_we      = 1'b0;
    rf_wdata   = alu_out;
    alu_op     = ALU_INC;
    halted     = 1'b0;
    instr_done = 1'b0;
    ir_ld      = 1'b0;
    mar_ld     = 1'b0;
    pc_ld      = 1'b0;
    case (state)
      S_BOOT: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_ld     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT)     state_nxt = S_HALT;
        else if (opcode <= OP_ST)  state_nxt = S_EXEC;
        else                       state_nxt = S_NEXTPC;
      end
      S_EXEC: begin
        alu_op = opcode;
        if (opcode <= OP_LI) begin
          rf_we     = 1'b1;
          state_nxt = S_NEXTPC;
        end else begin
          // ld/st: ALU computed the effective address
          mar_ld    = 1'b1;
          state_nxt = S_MEM;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = mar;
        mem_we   = (opcode == OP_ST);
        if (mem_ready) begin
          if (opcode == OP_LD) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
          end
          state_nxt = S_NEXTPC;
        end
      end
      S_NEXTPC: begin
        if ((opcode == OP_BZ && alu_zero) || (opcode == OP_BN && alu_neg)) alu_op = ALU_BR;
        else if (opcode == OP_J)                                          alu_op = ALU_J;
        else if (opcode == OP_JR)                                         alu_op = ALU_JR;
        else                                                              alu_op = ALU_INC;
        pc_ld      = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control with memory, register-file and ALU models.
// Latency: checks per-instruction cycle counts against the fixed sequencing.
// Backpressure: memory model inserts configurable wait states on data transfers.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  ra_sel, rb_sel, rf_waddr, alu_op;
  logic [15:0] a_data, rf_wdata, pc, alu_out;
  logic        rf_we, alu_neg, alu_zero, halted, instr_done;
  logic [11:0] inst12;

  cpu_control dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .a_data(a_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .inst12(inst12), .pc(pc),
    .alu_out(alu_out), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .halted(halted), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // ---------------- environment models ----------------
  logic [15:0] mem  [0:255];
  logic [15:0] regs [0:15];
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        poke_vld = 1'b0;
  logic        poke_mem = 1'b0;
  logic [7:0]  poke_addr = 8'h00;
  logic [15:0] poke_data = 16'h0000;
  logic [15:0] alu_a, alu_b;

  // Instruction fetches (address == pc) are zero-wait; data transfers wait mem_wait cycles
  assign mem_ready = mem_req && ((mem_addr == pc) || (wait_cnt >= mem_wait));
  assign mem_rdata = mem[mem_addr[7:0]];
  assign a_data    = regs[ra_sel];

  // Single writer for memory/regfile: DUT writes plus bench preloads
  always @(posedge clk) begin
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    if (mem_req && mem_ready && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (poke_vld) begin
      if (poke_mem) mem[poke_addr] <= poke_data;
      else          regs[poke_addr[3:0]] <= poke_data;
    end
    wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
  end

  // Reference ALU: flags come from port B
  always_comb begin
    alu_a = regs[ra_sel];
    alu_b = regs[rb_sel];
    case (alu_op)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a & alu_b;
      4'd3:    alu_out = alu_a | alu_b;
      4'd4:    alu_out = ~alu_a;
      4'd5:    alu_out = alu_a << 1;
      4'd6:    alu_out = alu_a >> 1;
      4'd7:    alu_out = {8'h00, inst12[7:0]};
      4'd8:    alu_out = alu_b + {12'h000, inst12[7:4]};
      4'd9:    alu_out = alu_b + {12'h000, inst12[11:8]};
      4'd10:   alu_out = pc + 16'd1;
      4'd11:   alu_out = pc + {{8{inst12[11]}}, inst12[11:4]};
      4'd12:   alu_out = {pc[15:12], inst12};
      4'd13:   alu_out = alu_a;
      default: alu_out = 16'h0000;
    endcase
    alu_neg  = alu_b[15];
    alu_zero = (alu_b == 16'h0000);
  end

  // ---------------- scoreboard / observer ----------------
  typedef struct packed { logic [3:0] addr; logic [15:0] data; logic [3:0] op; } wr_t;
  typedef struct packed { logic we; logic [15:0] addr; logic [15:0] wdata; } txn_t;

  wr_t  exp_wr [$];
  wr_t  obs_wr [$];
  txn_t obs_txn [$];
  int   cycles;
  bit   timed_out, unstable;
  logic [3:0] npc_op;

  task automatic clear_obs();
    exp_wr.delete(); obs_wr.delete(); obs_txn.delete();
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [15:0] d, input logic [3:0] op);
    wr_t w;
    w.addr = a; w.data = d; w.op = op;
    exp_wr.push_back(w);
  endtask

  // Runs one instruction starting in FETCH; returns at the negedge of the next FETCH or on HALT
  task automatic run_instr(input int budget);
    bit         done = 1'b0;
    bit         p_wait = 1'b0;
    logic [15:0] p_addr = 16'h0, p_wdata = 16'h0;
    logic        p_we = 1'b0;
    wr_t  w;
    txn_t t;
    cycles = 0; timed_out = 1'b0; unstable = 1'b0; npc_op = 4'hF;
    while (!done && halted !== 1'b1) begin
      cycles++;
      if (p_wait && mem_req && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
        unstable = 1'b1;
      p_wait = mem_req && !mem_ready;
      p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
      if (rf_we === 1'b1) begin
        w.addr = rf_waddr; w.data = rf_wdata; w.op = alu_op;
        obs_wr.push_back(w);
      end
      if (mem_req && mem_ready && mem_addr != pc) begin
        t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata;
        obs_txn.push_back(t);
      end
      if (instr_done === 1'b1) begin
        npc_op = alu_op;
        done   = 1'b1;
      end
      if (cycles > budget) begin
        timed_out = 1'b1;
        done      = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic poke(input logic m, input logic [7:0] a, input logic [15:0] d);
    poke_mem = m; poke_addr = a; poke_data = d; poke_vld = 1'b1;
    @(negedge clk);
    poke_vld = 1'b0;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
    checks++; if (halted !== 1'b0 || instr_done !== 1'b0) begin fails++; $display("FAIL reset_flags got halted=%b done=%b want 0/0", halted, instr_done); end
    checks++; if (pc !== 16'h0000 || inst12 !== 12'h000) begin fails++; $display("FAIL reset_pc_ir got pc=%h inst12=%h want 0/0", pc, inst12); end
    checks++; if (alu_op !== 4'd10) begin fails++; $display("FAIL reset_alu_op got %0d want 10", alu_op); end
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL boot_no_req got %b want 0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin fails++; $display("FAIL boot_to_fetch got req=%b we=%b addr=%h want 1/0/0000", mem_req, mem_we, mem_addr); end
  endtask

  task automatic test_alu();
    wr_t e, o;
    hold_reset();
    poke(1'b1, 8'h00, 16'h1123);
    poke(1'b0, 8'h02, 16'd9);
    poke(1'b0, 8'h03, 16'd7);
    release_reset();
    clear_obs();
    push_exp(4'd1, 16'd2, 4'd1);
    run_instr(20);
    checks++; if (timed_out || cycles != 4) begin fails++; $display("FAIL alu_latency got %0d cycles (timeout=%0b) want 4", cycles, timed_out); end
    checks++; if (obs_wr.size() != exp_wr.size()) begin fails++; $display("FAIL alu_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL alu_wr got addr=%0d data=%h op=%0d want addr=%0d data=%h op=%0d", o.addr, o.data, o.op, e.addr, e.data, e.op); end
    end
    checks++; if (pc !== 16'h0001 || mem_req !== 1'b1 || mem_addr !== 16'h0001) begin fails++; $display("FAIL alu_next_fetch got pc=%h req=%b addr=%h want 0001/1/0001", pc, mem_req, mem_addr); end
  endtask

  task automatic test_load_wait();
    wr_t e, o;
    txn_t t;
    hold_reset();
    poke(1'b1, 8'h00, 16'h8234);
    poke(1'b1, 8'h43, 16'hBEEF);
    poke(1'b0, 8'h04, 16'h0040);
    mem_wait = 2;
    release_reset();
    clear_obs();
    push_exp(4'd2, 16'hBEEF, 4'd10);
    run_instr(30);
    mem_wait = 0;
    checks++; if (timed_out || cycles != 7) begin fails++; $display("FAIL ld_latency got %0d cycles (timeout=%0b) want 7", cycles, timed_out); end
    checks++; if (obs_txn.size() != 1) begin fails++; $display("FAIL ld_txn_count got %0d want 1", obs_txn.size()); end
    else begin
      t = obs_txn.pop_front();
      checks++; if (t.we !== 1'b0 || t.addr !== 16'h0043) begin fails++; $display("FAIL ld_addr got we=%b addr=%h want 0/0043", t.we, t.addr); end
    end
    checks++; if (unstable) begin fails++; $display("FAIL ld_stable got unstable=1 want 0"); end
    checks++; if (obs_wr.size() != exp_wr.size()) begin fails++; $display("FAIL ld_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o.addr !== e.addr || o.data !== e.data) begin fails++; $display("FAIL ld_wr got addr=%0d data=%h want addr=%0d data=%h", o.addr, o.data, e.addr, e.data); end
    end
    checks++; if (pc !== 16'h0001) begin fails++; $display("FAIL ld_pc got %h want 0001", pc); end
  endtask

  task automatic test_store();
    txn_t t;
    hold_reset();
    poke(1'b1, 8'h00, 16'h9A56);
    poke(1'b0, 8'h05, 16'h1234);
    poke(1'b0, 8'h06, 16'h0050);
    release_reset();
    clear_obs();
    run_instr(30);
    checks++; if (timed_out || cycles != 5) begin fails++; $display("FAIL st_latency got %0d cycles (timeout=%0b) want 5", cycles, timed_out); end
    checks++; if (obs_wr.size() != 0) begin fails++; $display("FAIL st_no_rf_we got %0d writes want 0", obs_wr.size()); end
    checks++; if (obs_txn.size() != 1) begin fails++; $display("FAIL st_txn_count got %0d want 1", obs_txn.size()); end
    else begin
      t = obs_txn.pop_front();
      checks++; if (t.we !== 1'b1 || t.addr !== 16'h005A || t.wdata !== 16'h1234) begin fails++; $display("FAIL st_txn got we=%b addr=%h wdata=%h want 1/005A/1234", t.we, t.addr, t.wdata); end
    end
    checks++; if (mem[8'h5A] !== 16'h1234) begin fails++; $display("FAIL st_mem got %h want 1234", mem[8'h5A]); end
  endtask

  task automatic test_branch();
    // Not taken: port B (R3) positive
    hold_reset();
    poke(1'b1, 8'h00, 16'hF000);
    poke(1'b1, 8'h01, 16'hBFE3);
    poke(1'b1, 8'hFF, 16'hF000);
    poke(1'b0, 8'h03, 16'h0005);
    release_reset();
    run_instr(20);
    checks++; if (timed_out || cycles != 3 || pc !== 16'h0001) begin fails++; $display("FAIL nop_step got cycles=%0d pc=%h want 3/0001", cycles, pc); end
    run_instr(20);
    checks++; if (npc_op !== 4'd10 || pc !== 16'h0002) begin fails++; $display("FAIL bn_not_taken got op=%0d pc=%h want 10/0002", npc_op, pc); end
    // Taken: R3 negative, displacement -2 from pc 1 wraps to 0xFFFF
    hold_reset();
    poke(1'b0, 8'h03, 16'h8000);
    release_reset();
    run_instr(20);
    run_instr(20);
    checks++; if (timed_out || cycles != 3 || npc_op !== 4'd11) begin fails++; $display("FAIL bn_taken_op got cycles=%0d op=%0d want 3/11", cycles, npc_op); end
    checks++; if (pc !== 16'hFFFF || mem_addr !== 16'hFFFF) begin fails++; $display("FAIL bn_taken_pc got pc=%h addr=%h want FFFF/FFFF", pc, mem_addr); end
    run_instr(20);
    checks++; if (pc !== 16'h0000) begin fails++; $display("FAIL pc_wrap got %h want 0000", pc); end
  endtask

  task automatic test_halt();
    int bad = 0;
    hold_reset();
    poke(1'b1, 8'h00, 16'hE000);
    release_reset();
    run_instr(10);
    checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_enter got %b want 1", halted); end
    for (int i = 0; i < 20; i++) begin
      if (halted !== 1'b1 || mem_req !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL halt_hold got %0d bad cycles want 0", bad); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pc !== 16'h0000 || halted !== 1'b0) begin fails++; $display("FAIL halt_reset got pc=%h halted=%b want 0000/0", pc, halted); end
    reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL halt_boot got req=%b want 0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin fails++; $display("FAIL halt_refetch got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
  endtask

  task automatic test_reset_mid_mem();
    int  n = 0;
    bit  saw_we = 1'b0;
    hold_reset();
    poke(1'b1, 8'h00, 16'h8234);
    poke(1'b0, 8'h04, 16'h0040);
    mem_wait = 50;
    release_reset();
    while (!(mem_req === 1'b1 && mem_addr === 16'h0043) && n < 20) begin
      if (rf_we === 1'b1) saw_we = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++; if (n >= 20) begin fails++; $display("FAIL rst_mem_reach got timeout want MEM request"); end
    @(negedge clk);
    if (rf_we === 1'b1) saw_we = 1'b1;
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req_drop got %b want 0", mem_req); end
    checks++; if (rf_we !== 1'b0 || saw_we) begin fails++; $display("FAIL rst_mem_no_rf_we got rf_we=%b seen=%0b want 0/0", rf_we, saw_we); end
    checks++; if (pc !== 16'h0000) begin fails++; $display("FAIL rst_mem_pc got %h want 0000", pc); end
    mem_wait = 0;
    @(negedge clk);
    release_reset();
  endtask

  task automatic test_back_to_back();
    wr_t e, o;
    int  n_done = 0;
    int  total = 0;
    logic [3:0] last_op = 4'hF;
    hold_reset();
    poke(1'b1, 8'h00, 16'h7312);   // li  R3 = 0x12
    poke(1'b1, 8'h01, 16'h0435);   // add R4 = R3 + R5
    poke(1'b1, 8'h02, 16'h5640);   // shl R6 = R4 << 1
    poke(1'b1, 8'h03, 16'hC008);   // j   0x008
    poke(1'b1, 8'h08, 16'hE000);   // halt
    poke(1'b0, 8'h05, 16'h0100);
    release_reset();
    clear_obs();
    push_exp(4'd3, 16'h0012, 4'd7);
    push_exp(4'd4, 16'h0112, 4'd0);
    push_exp(4'd6, 16'h0224, 4'd5);
    for (int i = 0; i < 8 && halted !== 1'b1; i++) begin
      run_instr(20);
      if (halted !== 1'b1 && !timed_out) begin
        n_done++;
        total += cycles;
        last_op = npc_op;
      end
    end
    checks++; if (halted !== 1'b1 || pc !== 16'h0008) begin fails++; $display("FAIL b2b_end got halted=%b pc=%h want 1/0008", halted, pc); end
    checks++; if (n_done != 4 || total != 15) begin fails++; $display("FAIL b2b_timing got instrs=%0d cycles=%0d want 4/15", n_done, total); end
    checks++; if (last_op !== 4'd12) begin fails++; $display("FAIL b2b_jump_op got %0d want 12", last_op); end
    checks++; if (obs_wr.size() != exp_wr.size()) begin fails++; $display("FAIL b2b_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o !== e) begin fails++; $display("FAIL b2b_wr got addr=%0d data=%h op=%0d want addr=%0d data=%h op=%0d", o.addr, o.data, o.op, e.addr, e.data, e.op); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch();
    test_halt();
    test_reset_mid_mem();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
